// File: rtl/gf_mixcol_pipe_if.sv
// Handshake bundle for gf_mixcol_pipe: upstream (in_*) and downstream (out_*) channels.
// The in_bypass signal exists only when MIXCOL_BYPASS_EN is defined.
interface gf_mixcol_pipe_if #(
  parameter int unsigned NUM_COLS = 4
);
  localparam int unsigned W = 32 * NUM_COLS;

  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [W-1:0] in_data;
`ifdef MIXCOL_BYPASS_EN
  logic         in_bypass;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_mode;

  modport master (
    output in_valid, in_mode, in_data,
`ifdef MIXCOL_BYPASS_EN
    output in_bypass,
`endif
    output out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, in_mode, in_data,
`ifdef MIXCOL_BYPASS_EN
    input  in_bypass,
`endif
    input  out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/gf_mixcol_pipe.sv
// Pipelined AES MixColumns / InvMixColumns over NUM_COLS columns with valid/ready backpressure.
// Optional MIXCOL_BYPASS_EN adds in_bypass to pass data through unmixed (final AES round).
module gf_mixcol_pipe #(
  parameter int unsigned NUM_COLS = 4,
  parameter int unsigned OUT_REG  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  gf_mixcol_pipe_if.slave    bus,
  output logic               busy
);
  localparam int unsigned W  = 32 * NUM_COLS;
  localparam int unsigned NB = 4 * NUM_COLS;

  typedef logic [7:0] byte_t;

  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  byte_t        w_a  [NB];
  byte_t        w_a2 [NB];
  byte_t        w_a4 [NB];
  byte_t        w_a8 [NB];
  logic         w_in_fire;
  logic         w_in_bypass;
  logic         w_s1_adv;
  logic [W-1:0] w_mix;

  logic         r_s1_valid;
  logic         r_s1_mode;
  logic         r_s1_bypass;
  byte_t        r_a  [NB];
  byte_t        r_a2 [NB];
  byte_t        r_a4 [NB];
  byte_t        r_a8 [NB];

`ifdef MIXCOL_BYPASS_EN
  assign w_in_bypass = bus.in_bypass;
`else
  assign w_in_bypass = 1'b0;
`endif

  assign w_in_fire    = bus.in_valid & bus.in_ready;
  assign bus.in_ready = ~r_s1_valid | w_s1_adv;

  // Byte i = 4*col + row sits at bits [W-1-8i -: 8].
  always_comb begin
    for (int unsigned i = 0; i < NB; i++) begin
      w_a[i]  = bus.in_data[W-1-8*i -: 8];
      w_a2[i] = xtime(w_a[i]);
      w_a4[i] = xtime(w_a2[i]);
      w_a8[i] = xtime(w_a4[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= 1'b0;
      r_s1_bypass <= 1'b0;
      for (int unsigned i = 0; i < NB; i++) begin
        r_a[i]  <= '0;
        r_a2[i] <= '0;
        r_a4[i] <= '0;
        r_a8[i] <= '0;
      end
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_in_fire) begin
        r_s1_mode   <= bus.in_mode;
        r_s1_bypass <= w_in_bypass;
        for (int unsigned i = 0; i < NB; i++) begin
          r_a[i]  <= w_a[i];
          r_a2[i] <= w_a2[i];
          r_a4[i] <= w_a4[i];
          r_a8[i] <= w_a8[i];
        end
      end
    end
  end

  always_comb begin
    w_mix = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        int unsigned i0;
        int unsigned i1;
        int unsigned i2;
        int unsigned i3;
        byte_t       b;
        i0 = 4*c + r;
        i1 = 4*c + ((r + 1) % 4);
        i2 = 4*c + ((r + 2) % 4);
        i3 = 4*c + ((r + 3) % 4);
        if (r_s1_bypass) begin
          b = r_a[i0];
        end else if (r_s1_mode) begin
          b = (r_a8[i0] ^ r_a4[i0] ^ r_a2[i0])
            ^ (r_a8[i1] ^ r_a2[i1] ^ r_a[i1])
            ^ (r_a8[i2] ^ r_a4[i2] ^ r_a[i2])
            ^ (r_a8[i3] ^ r_a[i3]);
        end else begin
          b = r_a2[i0] ^ (r_a2[i1] ^ r_a[i1]) ^ r_a[i2] ^ r_a[i3];
        end
        w_mix[W-1-8*i0 -: 8] = b;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic         r_s2_valid;
    logic         r_s2_mode;
    logic [W-1:0] r_s2_data;
    logic         w_s2_adv;

    assign w_s2_adv = r_s2_valid & bus.out_ready;
    assign w_s1_adv = r_s1_valid & (~r_s2_valid | w_s2_adv);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_valid <= 1'b0;
        r_s2_mode  <= 1'b0;
        r_s2_data  <= '0;
      end else begin
        if (w_s1_adv) begin
          r_s2_valid <= 1'b1;
          r_s2_mode  <= r_s1_mode;
          r_s2_data  <= w_mix;
        end else if (w_s2_adv) begin
          r_s2_valid <= 1'b0;
        end
      end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_s2_data;
    assign bus.out_mode  = r_s2_mode;
    assign busy          = r_s1_valid | r_s2_valid;
  end else begin : g_out_comb
    assign w_s1_adv      = r_s1_valid & bus.out_ready;
    assign bus.out_valid = r_s1_valid;
    assign bus.out_data  = w_mix;
    assign bus.out_mode  = r_s1_mode;
    assign busy          = r_s1_valid;
  end
endmodule

// File: tb/tb_gf_mixcol_pipe.sv
// Self-checking bench for gf_mixcol_pipe against a bit-serial GF(2^8) matrix-multiply model.
module tb_gf_mixcol_pipe;
  localparam int unsigned NC  = 4;
  localparam int unsigned ORG = 1;
  localparam int unsigned W   = 32 * NC;
  localparam int          LAT = ORG + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic tb_byp = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [W-1:0] exp_d [$];
  logic         exp_m [$];

  gf_mixcol_pipe_if #(.NUM_COLS(NC)) bus ();

  gf_mixcol_pipe #(.NUM_COLS(NC), .OUT_REG(ORG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

`ifdef MIXCOL_BYPASS_EN
  assign bus.in_bypass = tb_byp;
`endif

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [W-1:0] ref_mix(input logic [W-1:0] d, input logic mode, input logic byp);
    logic [7:0]   k [4];
    logic [7:0]   col [4];
    logic [7:0]   acc;
    logic [W-1:0] res = '0;
    if (byp) return d;
    if (mode) begin
      k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    end else begin
      k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    end
    for (int c = 0; c < int'(NC); c++) begin
      for (int r = 0; r < 4; r++) col[r] = d[W-1-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int t = 0; t < 4; t++) acc = acc ^ gmul(col[(r+t)%4], k[t]);
        res[W-1-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] v;
    for (int i = 0; i < int'(NC); i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic cycle(input logic v, input logic m, input logic [W-1:0] d, input logic ordy,
                       output logic fi, output logic fo, output logic ov,
                       output logic [W-1:0] od, output logic om, output logic ir);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_mode   = m;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    ir = bus.in_ready;
    fi = v & ir;
    ov = bus.out_valid;
    fo = ov & ordy;
    od = bus.out_data;
    om = bus.out_mode;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    n_cmp++; if (bus.out_mode !== 1'b0) begin n_bad++; $display("FAIL reset_out_mode: got %b want 0", bus.out_mode); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_vectors();
    logic [31:0] vi [6] = '{32'hdb135345, 32'h8e4da1bc, 32'h01000000, 32'hc6c6c6c6, 32'hf20a225c, 32'hf20a225c};
    logic [31:0] ve [6] = '{32'h8e4da1bc, 32'hdb135345, 32'h0e090d0b, 32'hc6c6c6c6, 32'hf20a225c, 32'h9fdc589d};
    logic        vm [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        vb [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          nv;
    logic fi, fo, ov, om, ir;
    logic [W-1:0] od, din, got_d;
    logic got_m;
    int lat, pulses;
`ifdef MIXCOL_BYPASS_EN
    nv = 6;
`else
    nv = 4;
`endif
    for (int k = 0; k < nv; k++) begin
      din = {NC{vi[k]}};
      tb_byp = vb[k];
      cycle(1'b1, vm[k], din, 1'b1, fi, fo, ov, od, om, ir);
      n_cmp++; if (fi !== 1'b1) begin n_bad++; $display("FAIL vec%0d_accept: got %b want 1", k, fi); end
      tb_byp = 1'b0;
      lat = -1; pulses = 0; got_d = '0; got_m = 1'b0;
      for (int t = 1; t <= 8; t++) begin
        cycle(1'b0, $urandom_range(0, 1), rnd_data(), 1'b1, fi, fo, ov, od, om, ir);
        if (ov) begin
          pulses++;
          if (lat < 0) begin lat = t; got_d = od; got_m = om; end
        end
      end
      n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL vec%0d_latency: got %0d want %0d", k, lat, LAT); end
      n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL vec%0d_pulses: got %0d want 1", k, pulses); end
      n_cmp++; if (got_d !== {NC{ve[k]}}) begin n_bad++; $display("FAIL vec%0d_data: got %h want %h", k, got_d, {NC{ve[k]}}); end
      n_cmp++; if (got_d !== ref_mix(din, vm[k], vb[k])) begin n_bad++; $display("FAIL vec%0d_model: got %h want %h", k, got_d, ref_mix(din, vm[k], vb[k])); end
      n_cmp++; if (got_m !== vm[k]) begin n_bad++; $display("FAIL vec%0d_mode: got %b want %b", k, got_m, vm[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic fi, fo, ov, om, ir;
    logic [W-1:0] od, d;
    logic m, em;
    logic [W-1:0] ed;
    int sent = 0, got = 0, first = -1, last = -1, acc_cycles = 0;
    exp_d.delete(); exp_m.delete();
    for (int t = 0; t < 8 + LAT + 4; t++) begin
      m = sent[0];
      d = rnd_data();
      cycle(sent < 8, m, d, 1'b1, fi, fo, ov, od, om, ir);
      if (fi) begin exp_d.push_back(ref_mix(d, m, 1'b0)); exp_m.push_back(m); sent++; acc_cycles++; end
      if (fo) begin
        if (first < 0) first = t;
        last = t;
        got++;
        if (exp_d.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL b2b_spurious: got out_valid want none at cycle %0d", t);
        end else begin
          ed = exp_d.pop_front(); em = exp_m.pop_front();
          n_cmp++; if (od !== ed) begin n_bad++; $display("FAIL b2b_data: got %h want %h", od, ed); end
          n_cmp++; if (om !== em) begin n_bad++; $display("FAIL b2b_mode: got %b want %b", om, em); end
        end
      end
    end
    n_cmp++; if (acc_cycles !== 8) begin n_bad++; $display("FAIL b2b_accepted: got %0d want 8", acc_cycles); end
    n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL b2b_delivered: got %0d want 8", got); end
    n_cmp++; if (last - first !== 7) begin n_bad++; $display("FAIL b2b_consecutive: got span %0d want 7", last - first); end
  endtask

  task automatic test_backpressure();
    logic fi, fo, ov, om, ir;
    logic [W-1:0] od, ed;
    logic [W-1:0] txd [3];
    logic         txm [3];
    logic em;
    int idx = 0, got = 0;
    exp_d.delete(); exp_m.delete();
    for (int i = 0; i < 3; i++) begin txd[i] = rnd_data(); txm[i] = $urandom_range(0, 1); end
    for (int t = 0; t < 5; t++) begin
      cycle(idx < 3, idx < 3 ? txm[idx] : 1'b0, idx < 3 ? txd[idx] : '0, 1'b0, fi, fo, ov, od, om, ir);
      if (ov && exp_d.size() > 0) begin
        n_cmp++; if (od !== exp_d[0]) begin n_bad++; $display("FAIL bp_stall_data: got %h want %h", od, exp_d[0]); end
        n_cmp++; if (om !== exp_m[0]) begin n_bad++; $display("FAIL bp_stall_mode: got %b want %b", om, exp_m[0]); end
      end
      if (fi) begin exp_d.push_back(ref_mix(txd[idx], txm[idx], 1'b0)); exp_m.push_back(txm[idx]); idx++; end
      if (t == 4) begin
        n_cmp++; if (ir !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_full: got %b want 0", ir); end
      end
    end
    n_cmp++; if (idx !== LAT) begin n_bad++; $display("FAIL bp_accepted_while_stalled: got %0d want %0d", idx, LAT); end
    for (int t = 0; t < 20 && got < 3; t++) begin
      cycle(idx < 3, idx < 3 ? txm[idx] : 1'b0, idx < 3 ? txd[idx] : '0, 1'b1, fi, fo, ov, od, om, ir);
      if (fi) begin exp_d.push_back(ref_mix(txd[idx], txm[idx], 1'b0)); exp_m.push_back(txm[idx]); idx++; end
      if (fo) begin
        got++;
        ed = exp_d.pop_front(); em = exp_m.pop_front();
        n_cmp++; if (od !== ed) begin n_bad++; $display("FAIL bp_drain_data: got %h want %h", od, ed); end
        n_cmp++; if (om !== em) begin n_bad++; $display("FAIL bp_drain_mode: got %b want %b", om, em); end
      end
    end
    n_cmp++; if (got !== 3) begin n_bad++; $display("FAIL bp_delivered: got %0d want 3", got); end
  endtask

  task automatic test_random();
    logic fi, fo, ov, om, ir, v, m, r;
    logic [W-1:0] od, d, ed;
    logic em;
    int sent = 0, got = 0;
    exp_d.delete(); exp_m.delete();
    for (int t = 0; t < 420; t++) begin
      v = (t < 400) && ($urandom_range(0, 9) < 7);
      r = (t >= 400) || ($urandom_range(0, 9) < 6);
      m = $urandom_range(0, 1);
      d = rnd_data();
      cycle(v, m, d, r, fi, fo, ov, od, om, ir);
      if (fi) begin exp_d.push_back(ref_mix(d, m, 1'b0)); exp_m.push_back(m); sent++; end
      if (fo) begin
        got++;
        if (exp_d.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL rnd_spurious: got out_valid want none at cycle %0d", t);
        end else begin
          ed = exp_d.pop_front(); em = exp_m.pop_front();
          n_cmp++; if (od !== ed || om !== em) begin n_bad++; $display("FAIL rnd_result: got %h/%b want %h/%b", od, om, ed, em); end
        end
      end
    end
    n_cmp++; if (got !== sent) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", got, sent); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    logic fi, fo, ov, om, ir;
    logic [W-1:0] od;
    int acc = 0, stale = 0;
    for (int t = 0; t < 2; t++) begin
      cycle(1'b1, 1'b0, rnd_data(), 1'b0, fi, fo, ov, od, om, ir);
      if (fi) acc++;
    end
    cycle(1'b0, 1'b0, '0, 1'b0, fi, fo, ov, od, om, ir);
    n_cmp++; if (acc !== 2) begin n_bad++; $display("FAIL mrst_fill: got %0d want 2", acc); end
    n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL mrst_pre_valid: got %b want 1", ov); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      cycle(1'b0, 1'b0, rnd_data(), 1'b1, fi, fo, ov, od, om, ir);
      if (ov) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL mrst_stale: got %0d outputs want 0", stale); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gf_mixcol_pipe.md
Name: gf_mixcol_pipe

Overview:
- Parametrised, pipelined GF(2^8) column mixer for the AES datapath.
- Successor to the fixed multiply-by-constant lookup units. Computes full MixColumns (forward: 02,03,01,01) or InvMixColumns (inverse: 0e,0b,0d,09) on NUM_COLS 32-bit columns in parallel.
- Uses an xtime chain instead of per-constant tables.
- Sits between the ShiftRows/InvShiftRows stage and AddRoundKey in both the encrypt and decrypt round pipelines.
- Uses a valid/ready handshake with backpressure.

Parameters:
- NUM_COLS, 4, columns processed per transaction (1..4); data width W = 32*NUM_COLS.
- OUT_REG, 1, 1 = registered output stage (latency 2); 0 = output taken directly from stage 1 (latency 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  unit can accept input this cycle.
- in_mode  in  1  0 = forward MixColumns, 1 = InvMixColumns; sampled with in_data.
- in_data  in  W  column c occupies bits [W-1-32c -: 32]; within a column, row0 is in bits [31:24].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  W  mixed columns, same packing as in_data.
- out_mode  out  1  mode carried with the result.
- busy  out  1  any pipeline stage holds valid data.

Behaviour:
- Reset (async, rst_n=0): all stage valid flags = 0, out_valid = 0, out_data = 0, out_mode = 0, busy = 0. in_ready = 1 one cycle after deassertion.
  - Reset mid-operation discards all in-flight transactions; no partial result ever appears.
- Arithmetic: field polynomial x^8+x^4+x^3+x+1.
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00).
  - Per byte a, derive a2 = xtime(a), a4 = xtime(a2), a8 = xtime(a4).
  - 09 = a8^a; 0b = a8^a2^a; 0d = a8^a4^a; 0e = a8^a4^a2; 03 = a2^a.
- Forward output row r: b_r = 02*a_r ^ 03*a_(r+1) ^ a_(r+2) ^ a_(r+3), row indices mod 4.
- Inverse output row r: b_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3).
- Stage 1 (s1): register a, a2, a4, a8 for every byte, plus mode and valid.
- Stage 2 (s2, OUT_REG=1): register the combined XOR result, mode and valid.
- Latency: OUT_REG+1 cycles from the accepted input to out_valid, with no stalls. Throughput is 1 transaction/cycle.
- Elastic pipeline: a stage loads when it is empty or when its contents advance in the same cycle.
  - in_ready = ~s1_valid | s1_advance.
  - s2 advances on out_valid & out_ready.
- Transfers occur only on valid & ready at a clock edge.
- Stall: while out_valid=1 and out_ready=0, out_data and out_mode hold stable, and no input is lost or duplicated.
- Full: both stages valid with out_ready=0 gives in_ready=0 in the same cycle.
- Simultaneous accept and emit in one cycle is legal and keeps full rate.
- Mode may change on every transaction. Each result uses the mode sampled with its own input.
- busy = s1_valid | s2_valid.
- in_data and in_mode are ignored when in_valid=0. Stage data registers load only on transfer, to save power.

Optional Feature:
- Macro: MIXCOL_BYPASS_EN.
- Defined:
  - Adds input port in_bypass (1 bit), sampled with in_data and carried through the pipeline.
  - When set, out_data = in_data unmodified, with the same latency and handshake. This serves the final AES round, which skips MixColumns.
  - out_mode still reflects in_mode.
- Undefined: the port is absent and every transaction is mixed.

Test Plan:
- Forward, NUM_COLS=4, all columns db135345, mode 0 → every column 8e4da1bc after 2 cycles; out_valid pulses once.
- Inverse, mode 1, column 8e4da1bc → db135345. Column 01000000 → 0e090d0b. Column c6c6c6c6 → c6c6c6c6.
- Back-to-back: 8 transactions with alternating mode, out_ready=1 → 8 consecutive out_valid cycles, each result matching its own mode.
- Backpressure: out_ready=0 for 5 cycles with 3 transactions offered → in_ready drops after 2 are accepted and out_data stays stable. Releasing out_ready delivers all 3 in order with no loss.
- Reset: assert rst_n=0 while s1 and s2 are valid → out_valid=0 and busy=0 immediately; no stale output after release.
- With MIXCOL_BYPASS_EN defined: in_bypass=1, data f20a225c → f20a225c. in_bypass=0, same data → 9fdc589d.
